// File: rtl/gcd_operand_packer.sv
// gcd_operand_packer
//
// Packs a stream of words into (A, B) operand pairs for a GCD coprocessor and
// forwards the coprocessor results downstream through a one-entry buffer.
// Pairs are issued in arrival order (first word A, second word B). The number of
// issued-but-unreturned pairs is capped at MAX_OUT.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   in_val/in_bits/in_rdy      upstream word stream
//   operands_val/_bits_A/_bits_B/operands_rdy   pair request to coprocessor
//   result_val/result_bits/result_rdy           coprocessor response
//   out_val/out_bits/out_rdy   downstream result stream
//   outstanding                pairs currently in flight (0..MAX_OUT)
//   pairs_issued               total pairs issued, wraps at 16 bits
//
// in_rdy in the FULL state is combinationally derived from operands_rdy, so a
// new A word can be captured on the same edge the held pair leaves.

module gcd_operand_packer #(
  parameter int W       = 32,
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  input  logic [W-1:0] in_bits,
  output logic         in_rdy,
  output logic         operands_val,
  output logic [W-1:0] operands_bits_A,
  output logic [W-1:0] operands_bits_B,
  input  logic         operands_rdy,
  input  logic         result_val,
  input  logic [W-1:0] result_bits,
  output logic         result_rdy,
  output logic         out_val,
  output logic [W-1:0] out_bits,
  input  logic         out_rdy,
  output logic [3:0]   outstanding,
  output logic [15:0]  pairs_issued
);

  localparam logic [1:0] WAIT_A = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         out_val_r;
  logic [W-1:0] out_bits_r;
  logic [3:0]   outstanding_r;
  logic [15:0]  pairs_r;

  logic         slot_free_s;
  logic         operands_val_s;
  logic         in_rdy_s;
  logic         result_rdy_s;
  logic         out_val_s;
  logic         in_fire_s;
  logic         op_fire_s;
  logic         res_fire_s;
  logic         out_fire_s;
  logic         load_a_s;
  logic         load_b_s;

  // Handshake qualifiers; every ready/valid is forced low while reset is sampled
  // so nothing is issued or accepted in that cycle.
  always_comb begin
    slot_free_s    = (outstanding_r < MAX_OUT_C);
    operands_val_s = reset && (state_r == FULL) && slot_free_s;
    out_val_s      = reset && out_val_r;
    // A result may only be accepted if a pair is actually in flight.
    result_rdy_s   = reset && (outstanding_r != 4'd0) && (!out_val_r || out_rdy);
  end

  // Upstream ready: always open while a slot in the pair register is empty;
  // in FULL it opens only when the held pair leaves on this edge.
  always_comb begin
    in_rdy_s = 1'b0;
    if (!reset) begin
      in_rdy_s = 1'b0;
    end else begin
      case (state_r)
        WAIT_A:  in_rdy_s = 1'b1;
        WAIT_B:  in_rdy_s = 1'b1;
        FULL:    in_rdy_s = operands_val_s && operands_rdy;
        default: in_rdy_s = 1'b0;
      endcase
    end
  end

  // Transfer strobes for each channel.
  always_comb begin
    in_fire_s  = in_val && in_rdy_s;
    op_fire_s  = operands_val_s && operands_rdy;
    res_fire_s = result_val && result_rdy_s;
    out_fire_s = out_val_s && out_rdy;
  end

  // Pair FSM next state and which operand register captures the incoming word.
  always_comb begin
    state_nxt_s = state_r;
    load_a_s    = 1'b0;
    load_b_s    = 1'b0;
    case (state_r)
      WAIT_A: begin
        if (in_fire_s) begin
          state_nxt_s = WAIT_B;
          load_a_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT_A;
        end
      end
      WAIT_B: begin
        if (in_fire_s) begin
          state_nxt_s = FULL;
          load_b_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT_B;
        end
      end
      FULL: begin
        // in_fire implies op_fire here, so the new word starts the next pair.
        if (op_fire_s && in_fire_s) begin
          state_nxt_s = WAIT_B;
          load_a_s    = 1'b1;
        end else if (op_fire_s) begin
          state_nxt_s = WAIT_A;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = WAIT_A;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= WAIT_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand registers; only written on an accepted word, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      if (load_a_s) begin
        a_r <= in_bits;
      end
      if (load_b_s) begin
        b_r <= in_bits;
      end
    end
  end

  // In-flight pair counter; simultaneous issue and return cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding_r <= 4'd0;
    end else begin
      case ({op_fire_s, res_fire_s})
        2'b10:   outstanding_r <= outstanding_r + 4'd1;
        2'b01:   outstanding_r <= outstanding_r - 4'd1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Issued pair counter, free-running wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pairs_r <= 16'd0;
    end else if (op_fire_s) begin
      pairs_r <= pairs_r + 16'd1;
    end
  end

  // One-entry result buffer; a new result may replace one leaving on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_val_r  <= 1'b0;
      out_bits_r <= '0;
    end else if (res_fire_s) begin
      out_val_r  <= 1'b1;
      out_bits_r <= result_bits;
    end else if (out_fire_s) begin
      out_val_r  <= 1'b0;
    end
  end

  assign in_rdy          = in_rdy_s;
  assign operands_val    = operands_val_s;
  assign operands_bits_A = a_r;
  assign operands_bits_B = b_r;
  assign result_rdy      = result_rdy_s;
  assign out_val         = out_val_s;
  assign out_bits        = out_bits_r;
  assign outstanding     = outstanding_r;
  assign pairs_issued    = pairs_r;

endmodule

// File: tb/tb_gcd_operand_packer.sv
module tb_gcd_operand_packer;

  localparam int W       = 32;
  localparam int MAX_OUT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_val;
  logic [W-1:0] in_bits;
  logic         in_rdy;
  logic         operands_val;
  logic [W-1:0] operands_bits_A;
  logic [W-1:0] operands_bits_B;
  logic         operands_rdy;
  logic         result_val;
  logic [W-1:0] result_bits;
  logic         result_rdy;
  logic         out_val;
  logic [W-1:0] out_bits;
  logic         out_rdy;
  logic [3:0]   outstanding;
  logic [15:0]  pairs_issued;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected pairs and expected downstream results, in order
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] exp_out[$];
  logic         pend_valid;
  logic [W-1:0] pend_word;

  // environment controls (written by main at negedges)
  int op_mode  = 0;   // 0 never ready, 1 always, 2 random
  int out_mode = 0;
  int res_grant = 0;  // total results the coprocessor may return
  int res_used  = 0;
  bit res_random = 1'b0;
  int stall_cnt = 0;

  logic [W-1:0] cop_q[$];

  gcd_operand_packer #(.W(W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_bits(in_bits), .in_rdy(in_rdy),
    .operands_val(operands_val), .operands_bits_A(operands_bits_A),
    .operands_bits_B(operands_bits_B), .operands_rdy(operands_rdy),
    .result_val(result_val), .result_bits(result_bits), .result_rdy(result_rdy),
    .out_val(out_val), .out_bits(out_bits), .out_rdy(out_rdy),
    .outstanding(outstanding), .pairs_issued(pairs_issued)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send_word(input logic [W-1:0] w);
    bit acc;
    acc = 1'b0;
    in_val  = 1'b1;
    in_bits = w;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      if (in_rdy) acc = 1'b1;
      else stall_cnt++;
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_word_timeout: word %0d not accepted, required acceptance", w);
    end else if (pend_valid) begin
      exp_a.push_back(pend_word);
      exp_b.push_back(w);
      exp_out.push_back(gcd_ref(pend_word, w));
      pend_valid = 1'b0;
    end else begin
      pend_word  = w;
      pend_valid = 1'b1;
    end
  endtask

  // One cycle of reset, called at posedge+1.
  task automatic do_reset();
    reset = 1'b0;
    pend_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // coprocessor and downstream sink model
  initial begin
    logic rs, of, rf;
    logic [W-1:0] a, b;
    operands_rdy = 1'b0;
    result_val   = 1'b0;
    result_bits  = '0;
    out_rdy      = 1'b0;
    forever begin
      @(negedge clk);
      rs = reset;
      of = operands_val && operands_rdy;
      rf = result_val && result_rdy;
      a  = operands_bits_A;
      b  = operands_bits_B;
      @(posedge clk);
      #1;
      if (!rs) begin
        cop_q.delete();
      end else begin
        if (rf) begin
          if (cop_q.size() > 0) void'(cop_q.pop_front());
          res_used++;
        end
        if (of) cop_q.push_back(gcd_ref(a, b));
      end
      operands_rdy = (op_mode == 1) || (op_mode == 2 && $urandom_range(0, 1) == 1);
      out_rdy      = (out_mode == 1) || (out_mode == 2 && $urandom_range(0, 1) == 1);
      result_val   = (cop_q.size() > 0) && (res_used < res_grant) &&
                     (!res_random || $urandom_range(0, 1) == 1);
      result_bits  = (cop_q.size() > 0) ? cop_q[0] : '0;
    end
  end

  // monitor: pops the scoreboard on every transfer, tracks counters, checks stability
  initial begin
    int m_out;
    int m_pairs;
    bit hold_op, hold_out;
    logic [W-1:0] h_a, h_b, h_out;
    logic [W-1:0] ea, eb, eo;
    m_out = 0; m_pairs = 0; hold_op = 1'b0; hold_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_a.delete(); exp_b.delete(); exp_out.delete();
        m_out = 0; m_pairs = 0; hold_op = 1'b0; hold_out = 1'b0;
        check("in_rdy_in_reset", 32'(in_rdy), 32'd0);
        check("result_rdy_in_reset", 32'(result_rdy), 32'd0);
      end else begin
        if (hold_op) begin
          check("operands_val_hold", 32'(operands_val), 32'd1);
          check("operands_A_stable", operands_bits_A, h_a);
          check("operands_B_stable", operands_bits_B, h_b);
        end
        if (hold_out) begin
          check("out_val_hold", 32'(out_val), 32'd1);
          check("out_bits_stable", out_bits, h_out);
        end
        if (outstanding == 4'd0) check("result_rdy_idle", 32'(result_rdy), 32'd0);
        if (operands_val && operands_rdy) begin
          if (exp_a.size() == 0) begin
            check("unexpected_pair", 32'(exp_a.size()), 32'd1);
          end else begin
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            check("pair_A", operands_bits_A, ea);
            check("pair_B", operands_bits_B, eb);
          end
          m_out++;
          m_pairs++;
        end
        if (result_val && result_rdy) m_out--;
        if (out_val && out_rdy) begin
          if (exp_out.size() == 0) begin
            check("unexpected_out", 32'(exp_out.size()), 32'd1);
          end else begin
            eo = exp_out.pop_front();
            check("out_bits", out_bits, eo);
          end
        end
        hold_op  = operands_val && !operands_rdy;
        h_a      = operands_bits_A;
        h_b      = operands_bits_B;
        hold_out = out_val && !out_rdy;
        h_out    = out_bits;
      end
      @(posedge clk);
      #1;
      check("outstanding", 32'(outstanding), 32'(m_out));
      check("pairs_issued", 32'(pairs_issued), 32'(m_pairs & 16'hFFFF));
      check("outstanding_max", 32'(outstanding <= 4'(MAX_OUT)), 32'd1);
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // main stimulus
  initial begin
    in_val = 1'b0; in_bits = '0; reset = 1'b0; pend_valid = 1'b0; pend_word = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_operands_val", 32'(operands_val), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_pairs", 32'(pairs_issued), 32'd0);
    check("rst_A", operands_bits_A, 32'd0);
    check("rst_B", operands_bits_B, 32'd0);
    check("rst_out_bits", out_bits, 32'd0);

    // single pair 12,18
    op_mode = 1;
    @(posedge clk); #1;
    send_word(32'd12);
    send_word(32'd18);
    for (int k = 0; k < 20 && pairs_issued != 16'd1; k++) @(negedge clk);
    @(negedge clk);
    check("single_pairs", 32'(pairs_issued), 32'd1);
    check("single_outstanding", 32'(outstanding), 32'd1);

    // result 6 buffered while downstream stalls
    out_mode = 0;
    res_grant = res_used + 1;
    for (int k = 0; k < 20 && !out_val; k++) @(negedge clk);
    check("buf_out_val", 32'(out_val), 32'd1);
    check("buf_out_bits", out_bits, 32'd6);
    repeat (3) @(negedge clk);
    check("buf_out_held", out_bits, 32'd6);

    // cap at MAX_OUT: third pair held
    @(posedge clk); #1;
    send_word(32'd10); send_word(32'd4);
    send_word(32'd9);  send_word(32'd6);
    send_word(32'd8);  send_word(32'd12);
    repeat (2) @(negedge clk);
    check("cap_operands_val", 32'(operands_val), 32'd0);
    check("cap_outstanding", 32'(outstanding), 32'd2);
    check("cap_in_rdy", 32'(in_rdy), 32'd0);
    res_grant = res_used + 1;
    repeat (3) @(negedge clk);
    check("stall_result_val", 32'(result_val), 32'd1);
    check("stall_result_rdy", 32'(result_rdy), 32'd0);
    out_mode = 1;
    for (int k = 0; k < 20 && !(result_val && result_rdy); k++) @(negedge clk);
    check("cap_result_fire", 32'(result_val && result_rdy), 32'd1);
    @(negedge clk);
    check("cap_issue_next", 32'(operands_val), 32'd1);

    // simultaneous issue and return at outstanding=1
    op_mode = 0;
    res_grant = res_used + 1;
    for (int k = 0; k < 20 && outstanding != 4'd1; k++) @(negedge clk);
    @(posedge clk); #1;
    send_word(32'd14);
    send_word(32'd21);
    @(negedge clk);
    check("sim_pre_outstanding", 32'(outstanding), 32'd1);
    op_mode = 1;
    res_grant = res_used + 1;
    @(negedge clk);
    check("sim_both_fire", 32'({operands_val && operands_rdy, result_val && result_rdy}), 32'd3);
    @(posedge clk); #1;
    check("sim_outstanding", 32'(outstanding), 32'd1);

    // zero-bubble streaming of words 1..8
    @(negedge clk);
    op_mode = 1; out_mode = 1; res_grant = 1000000; res_random = 1'b0;
    @(posedge clk); #1;
    stall_cnt = 0;
    for (int i = 1; i <= 8; i++) send_word(32'(i));
    check("stream_stalls", 32'(stall_cnt), 32'd0);
    for (int k = 0; k < 20 && pairs_issued != 16'd9; k++) @(negedge clk);
    check("stream_pairs", 32'(pairs_issued), 32'd9);

    // randomized traffic
    @(negedge clk);
    op_mode = 2; out_mode = 2; res_random = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) begin
      send_word(32'($urandom_range(1, 5000)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    op_mode = 1; out_mode = 1;
    for (int k = 0; k < 1000 && (exp_out.size() != 0 || outstanding != 4'd0); k++) @(negedge clk);
    check("drain_exp_out", 32'(exp_out.size()), 32'd0);

    // reset discards a buffered result and a held pair
    out_mode = 0;
    @(posedge clk); #1;
    send_word(32'd9); send_word(32'd3);
    for (int k = 0; k < 50 && !(out_val && outstanding == 4'd0); k++) @(negedge clk);
    check("pre_rst_out_val", 32'(out_val), 32'd1);
    op_mode = 0;
    @(posedge clk); #1;
    send_word(32'd20); send_word(32'd30);
    @(negedge clk);
    check("pre_rst_held", 32'(operands_val), 32'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("post_rst_out_val", 32'(out_val), 32'd0);
    check("post_rst_operands_val", 32'(operands_val), 32'd0);
    check("post_rst_in_rdy", 32'(in_rdy), 32'd1);

    // held A=7 discarded by reset; 5,10 forms the next pair
    @(posedge clk); #1;
    send_word(32'd7);
    do_reset();
    @(negedge clk);
    op_mode = 1; out_mode = 1;
    @(posedge clk); #1;
    send_word(32'd5);
    send_word(32'd10);
    for (int k = 0; k < 20 && pairs_issued != 16'd1; k++) @(negedge clk);
    check("after_rst_pairs", 32'(pairs_issued), 32'd1);
    for (int k = 0; k < 50 && (exp_out.size() != 0 || out_val); k++) @(negedge clk);
    check("final_exp_pairs", 32'(exp_a.size()), 32'd0);
    check("final_exp_out", 32'(exp_out.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_operand_packer.md
GCD_OPERAND_PACKER -- requirements
Module: gcd_operand_packer

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter MAX_OUT, default 4, meaning maximum issued-but-unreturned operand pairs, range 1..15.
REQ-003 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-low reset.
REQ-004 SHALL have ports: in_val input 1, in_bits input W, in_rdy output 1: upstream word stream.
REQ-005 SHALL have ports: operands_val output 1, operands_bits_A output W, operands_bits_B output W, operands_rdy input 1: request to the coprocessor.
REQ-006 SHALL have ports: result_val input 1, result_bits input W, result_rdy output 1: response from the coprocessor.
REQ-007 SHALL have ports: out_val output 1, out_bits output W, out_rdy input 1: downstream result stream.
REQ-008 SHALL have ports: outstanding output 4, the in-flight pair count; pairs_issued output 16, the issued pair count.

Function
REQ-009 A transfer on any val/rdy channel SHALL occur exactly on a rising clk edge where val and rdy are both 1.
REQ-010 The FSM SHALL have three states: WAIT_A (no word held), WAIT_B (A held), FULL (A and B held).
REQ-011 WAIT_A SHALL capture in_bits into the A register on an in transfer and move to WAIT_B.
REQ-012 WAIT_B SHALL capture in_bits into the B register on an in transfer and move to FULL.
REQ-013 operands_val SHALL be 1 only in FULL with outstanding < MAX_OUT; operands_bits_A/B SHALL be driven from registers only.
REQ-014 In FULL, an operands transfer with no in transfer SHALL move the FSM to WAIT_A.
REQ-015 In FULL, simultaneous operands and in transfers SHALL capture the new word as A and move to WAIT_B (zero-bubble).
REQ-016 in_rdy SHALL be 1 in WAIT_A and WAIT_B, and in FULL SHALL equal operands_val AND operands_rdy (combinational path, documented).
REQ-017 operands_bits_A/B SHALL hold stable while operands_val=1 and operands_rdy=0.
REQ-018 The first word of each pair SHALL be A and the second B, with no reordering; the pair is issued exactly once.
REQ-019 The output buffer SHALL be a one-entry register; result_rdy SHALL be (NOT out_val) OR out_rdy.
REQ-020 A result transfer SHALL load result_bits into out_bits and set out_val=1 on the next cycle; out_val SHALL clear on an out transfer with no simultaneous result transfer.
REQ-021 Result latency from result transfer to out_val SHALL be exactly 1 cycle; back-to-back throughput SHALL be 1 result/cycle when out_rdy=1.
REQ-022 outstanding SHALL increment on an operands transfer and decrement on a result transfer; when both occur it SHALL be unchanged.
REQ-023 outstanding SHALL never exceed MAX_OUT, never underflow, and SHALL ignore result_val when outstanding=0 (result_rdy forced 0 in that case).
REQ-024 pairs_issued SHALL increment by 1 per operands transfer, wrapping from 16'hFFFF to 0.
REQ-025 out_bits and operands_bits SHALL be unchanged when the corresponding val is 0 (no X or spurious change).

Reset
REQ-026 While reset=0 at a clk edge, the FSM SHALL go to WAIT_A and SHALL set operands_val=0, out_val=0, outstanding=0, pairs_issued=0, and the A/B/out data registers to 0.
REQ-027 in_rdy and result_rdy SHALL be 0 during the cycle reset=0 is sampled, and SHALL take their normal values from the first cycle after reset=1.
REQ-028 Reset asserted mid-operation SHALL discard a held A, held pair and buffered result without issuing them, and the first word after reset SHALL be treated as A.

Verification
REQ-029 Stream words 12,18 with operands_rdy=1 -> one operands transfer A=12 B=18; pairs_issued=1; outstanding=1.
REQ-030 Hold operands_rdy=1, in_val=1 continuously with words 1..8 -> 4 pairs issued on consecutive eligible cycles, FULL->WAIT_B transitions, no lost words.
REQ-031 MAX_OUT=2, with result_val=0, push 3 pairs -> third pair held with operands_val=0 and outstanding=2; one result transfer -> third pair issues the next cycle.
REQ-032 result 6 arrives with out_rdy=0 -> out_val=1 with out_bits=6 held; second result_val stalled (result_rdy=0) until out_rdy=1.
REQ-033 Simultaneous operands and result transfers at outstanding=1 -> outstanding stays 1.
REQ-034 After word A=7 is accepted, assert reset=0 for 1 cycle, then send 5,10 -> issued pair A=5 B=10; 7 is never issued.
